// File: rtl/sram_arb_pkg.sv
// Shared defaults and the pipeline-stage record for the SRAM round-robin arbiter.
// Stage fields are sized for the widest legal configuration and sliced by the users.
package sram_arb_pkg;
  localparam int BPW_DEF  = 16;
  localparam int WORD_DEF = 128;
  localparam int NREQ_MAX = 8;
  localparam int ID_W     = $clog2(NREQ_MAX);
  localparam int ADDR_MAX = 32;
  localparam int BPW_MAX  = 64;

  typedef struct packed {
    logic                valid;
    logic                we;
    logic [ID_W-1:0]     id;
    logic [ADDR_MAX-1:0] addr;
    logic [BPW_MAX-1:0]  wdata;
  } stage_t;
endpackage

// File: rtl/sram_arb_rr_grant.sv
// One-hot grant picker: first requester at or after ptr_i, wrapping.
// SRAM_ARB_FIXED_PRIO_EN switches to fixed priority (lowest index wins, ptr_i ignored).
module sram_arb_rr_grant import sram_arb_pkg::*; #(
  parameter int  NREQ = 2,
  localparam int PW   = $clog2(NREQ)
)(
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o
);
  int start;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
  assign start = 0;
`else
  assign start = int'(ptr_i);
`endif

  always_comb begin
    gnt_o = '0;
    for (int off = 0; off < NREQ; off++)
      for (int i = 0; i < NREQ; i++)
        if (gnt_o == '0 && req_i[i] && i == (start + off) % NREQ) gnt_o[i] = 1'b1;
  end
endmodule

// File: rtl/sram_rr_arbiter.sv
// N-requester single-port SRAM front end: accept (N), SRAM access (N+1), capture Q (N+2), rsp pulse (N+3).
// Define SRAM_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module sram_rr_arbiter import sram_arb_pkg::*; #(
  parameter int BPW  = BPW_DEF,
  parameter int WORD = WORD_DEF,
  parameter int ADDR = $clog2(WORD),
  parameter int NREQ = 2
)(
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*ADDR-1:0] req_addr,
  input  logic [NREQ*BPW-1:0]  req_wdata,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [BPW-1:0]       rsp_rdata,
  output logic                 CEN,
  output logic                 WEN,
  output logic [ADDR-1:0]      A,
  output logic [BPW-1:0]       D,
  input  logic [BPW-1:0]       Q
);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt;
  stage_t          acc, s1_d, s1_q, s2_q;
  logic [NREQ-1:0] rsp_valid_d, rsp_valid_q;
  logic [BPW-1:0]  rdata_q;

  sram_arb_rr_grant #(.NREQ(NREQ)) u_grant (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  assign req_ready = gnt;

  // Payload of the granted requester; the pointer moves past the winner.
  always_comb begin
    acc   = '0;
    ptr_d = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        acc.valid = 1'b1;
        acc.we    = req_we[i];
        acc.id    = ID_W'(i);
        acc.addr  = ADDR_MAX'(req_addr[i*ADDR +: ADDR]);
        acc.wdata = BPW_MAX'(req_wdata[i*BPW +: BPW]);
        ptr_d     = PW'((i + 1) % NREQ);
      end
    end
  end

  // A and D hold their last driven values while the SRAM is idle.
  always_comb begin
    s1_d       = s1_q;
    s1_d.valid = 1'b0;
    if (acc.valid) s1_d = acc;
  end

  always_comb begin
    rsp_valid_d = '0;
    for (int i = 0; i < NREQ; i++)
      if (s2_q.valid && !s2_q.we && s2_q.id == ID_W'(i)) rsp_valid_d[i] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ptr_q       <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      s1_q        <= s1_d;
      s2_q        <= s1_q;
      rsp_valid_q <= rsp_valid_d;
      if (s2_q.valid && !s2_q.we) rdata_q <= Q;
    end
  end

  assign CEN       = ~s1_q.valid;
  assign WEN       = ~(s1_q.valid & s1_q.we);
  assign A         = s1_q.addr[ADDR-1:0];
  assign D         = s1_q.wdata[BPW-1:0];
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;

  logic unused_s2;
  assign unused_s2 = ^{s2_q.addr, s2_q.wdata};
endmodule
